hdlc_tx_framer: RTL and testbench
=================================

HDLC_TX_FRAMER -- requirements
Module: hdlc_tx_framer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: in_valid  input  1  upstream byte available.
REQ-004 SHALL have port: in_data  input  8  payload byte, transmitted LSB first.
REQ-005 SHALL have port: in_last  input  1  qualifies in_data as final byte of frame.
REQ-006 SHALL have port: in_ready  output  1  combinational; byte transfers on the edge where in_valid && in_ready.
REQ-007 SHALL have port: abort  input  1  request abort of current frame (sampled in DATA only).
REQ-008 SHALL have port: dout  output  1  registered serial line bit; one bit launched per clock.
REQ-009 SHALL have port: underrun  output  1  registered one-cycle pulse: in_valid low when a mid-frame byte was needed.
REQ-010 SHALL have port: busy  output  1  registered; high in any state other than IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, DATA, STUFF, ABORT7, DRAIN.
REQ-012 IDLE SHALL launch flag 0,1,1,1,1,1,1,0 continuously via 3-bit flag_idx, wrapping 7->0.
REQ-013 in_ready SHALL be high in IDLE only when flag_idx==7 (last flag bit launching) or in DRAIN.
REQ-014 A byte accepted in IDLE SHALL have bit0 launched on the edge after the closing 0 of the flag; state -> DATA.
REQ-015 DATA SHALL launch shift-register bits 0..7 in order, tracking ones_cnt (0..5) of consecutive 1s on dout since the last flag/0.
REQ-016 When ones_cnt==5, the next launched bit SHALL be a stuffed 0 (state STUFF, one cycle), payload bit held, ones_cnt cleared.
REQ-017 Stuffing SHALL also apply after the last payload bit before the closing flag.
REQ-018 Flag and abort bits SHALL never be stuffed and SHALL clear ones_cnt.
REQ-019 In DATA with bit7 launching, ones_cnt<5, byte not last: in_ready SHALL be high; accepted byte's bit0 launches next edge, no gap.
REQ-020 After last byte's bit7 (and any stuff bit) SHALL return to IDLE with flag_idx=0, so closing flag follows immediately and at least one full flag separates frames.
REQ-021 Underrun (in_ready high in DATA, in_valid low) SHALL pulse underrun and terminate the frame per REQ-030/031.
REQ-022 busy SHALL be low in IDLE, high in DATA, STUFF, ABORT7, DRAIN.
REQ-023 abort and accepted last byte in same cycle: abort SHALL win.

Reset
REQ-024 On reset: state IDLE, flag_idx 0, ones_cnt 0, dout 1, underrun 0, busy 0, shift register 0.
REQ-025 Reset mid-frame SHALL discard frame immediately; first edge after release launches flag bit 0 (value 0).
REQ-026 in_ready SHALL be 0 while reset is asserted.

Configuration
REQ-027 Macro HDLC_TX_ABORT_EN SHALL control abort support.
REQ-028 Defined: abort high in DATA/STUFF SHALL go ABORT7, launching seven 1s, then IDLE at flag_idx 0.
REQ-029 Defined: if abort occurs before the in_last byte is accepted, ABORT7 SHALL be followed by DRAIN, accepting/discarding bytes until in_last accepted, emitting flags meanwhile.
REQ-030 Defined: underrun SHALL behave as abort without DRAIN.
REQ-031 Undefined: abort input ignored; ABORT7/DRAIN unreachable; underrun closes frame with flag (IDLE, flag_idx 0).

Structure
REQ-032 Shared package hdlc_pkg SHALL hold state enum, HDLC_FLAG constant 8'h7E, STUFF_LIMIT=5, ABORT_LEN=7 (shared with the receiver).
REQ-033 Sub-module hdlc_bit_stuffer SHALL own ones_cnt and stuff-insert decision; FSM and handshake in top.

Verification
REQ-034 Reset release, in_valid=0 -> dout repeats 0,1,1,1,1,1,1,0 from first edge; busy 0.
REQ-035 Single byte 0xFF last -> flag, then 1,1,1,1,1,0,1,1,1, then 0,1,1,1,1,1,1,0.
REQ-036 Byte 0x7E last -> 0,1,1,1,1,1,0(stuff),1,0, then closing flag; receiver sees no false flag.
REQ-037 Bytes 0x0F,0xF0(last) back-to-back -> in_ready pulses exactly once per byte at bit7; zero idle bits between bytes.
REQ-038 ABORT_EN, abort during byte 1 of 3 -> seven 1s, flags, bytes 2-3 drained, busy low after in_last accepted.
REQ-039 in_valid dropped mid-frame -> underrun 1 for one cycle; ABORT_EN: seven 1s; else closing flag.

Source files
------------

// File: rtl/hdlc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdlc_pkg
// Description : Constants and types shared by the HDLC transmit framer and the
//               matching receiver (flag pattern, stuffing and abort lengths,
//               transmitter state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package hdlc_pkg;

  // Transmitter state encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_STUFF  = 3'd2,
    ST_ABORT7 = 3'd3,
    ST_DRAIN  = 3'd4
  } hdlc_state_e;

  // Opening/closing flag, sent LSB first: 0,1,1,1,1,1,1,0
  localparam logic [7:0] HDLC_FLAG = 8'h7E;

  // Consecutive payload ones after which a zero is inserted
  localparam int STUFF_LIMIT = 5;

  // Number of ones sent to abort a frame
  localparam int ABORT_LEN = 7;

  // Flag bit launched for a given position within the flag
  function automatic logic flag_bit(input logic [2:0] idx);
    return HDLC_FLAG[idx];
  endfunction

endpackage
`default_nettype wire

// File: rtl/hdlc_bit_stuffer.sv
`default_nettype none
// ============================================================================
// Module      : hdlc_bit_stuffer
// Description : Tracks the run of consecutive payload ones on the serial line
//               and flags when the next launched bit must be a stuffed zero.
//               Any launch that is not a payload bit (flag, abort, stuffed
//               zero) breaks the run.
// Revision    : 1.0 - initial release
// ============================================================================
module hdlc_bit_stuffer
  import hdlc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic payload_en,   // a payload bit is launched on this edge
  input  logic payload_bit,  // value of the payload bit being considered
  output logic stuff_req     // launching payload_bit completes a run of ones
);

  localparam logic [2:0] C_RUN_BEFORE_STUFF = 3'(STUFF_LIMIT - 1);

  logic [2:0] ones_cnt_q;
  logic [2:0] ones_cnt_d;

  // Next run length: grows on launched payload ones, clears on anything else
  always_comb begin
    ones_cnt_d = 3'd0;
    if (payload_en && payload_bit) begin
      ones_cnt_d = ones_cnt_q + 3'd1;
    end
  end

  // A one launched on top of a run of four makes five: stuff next
  always_comb begin
    stuff_req = payload_bit && (ones_cnt_q == C_RUN_BEFORE_STUFF);
  end

  // Run-length register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ones_cnt_q <= 3'd0;
    end else begin
      ones_cnt_q <= ones_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hdlc_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : hdlc_tx_framer
// Description : HDLC transmit framer. Sends continuous flags while idle,
//               serialises payload bytes LSB first with zero-bit stuffing,
//               chains back-to-back bytes without gaps and closes each frame
//               with a flag. Underrun ends the frame early.
//               Build option HDLC_TX_ABORT_EN: honours the abort input
//               (seven ones, then drain of the remaining frame bytes) and
//               turns underrun into an abort sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module hdlc_tx_framer
  import hdlc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       abort,
  output logic       dout,
  output logic       underrun,
  output logic       busy
);

  localparam logic [2:0] C_LAST_BIT   = 3'd7;
  localparam logic [2:0] C_ABORT_LAST = 3'(ABORT_LEN - 1);

  hdlc_state_e state_q, state_d;
  logic [2:0]  flag_idx_q, flag_idx_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        last_q, last_d;        // current byte closes the frame
  logic        tail_q, tail_d;        // pending stuff bit follows bit7
  logic        drain_q, drain_d;      // frame remainder must be discarded
  logic [2:0]  abort_cnt_q, abort_cnt_d;
  logic        dout_q, dout_d;
  logic        underrun_q, underrun_d;
  logic        busy_q, busy_d;

  logic        w_payload_en;
  logic        w_stuff_req;
  logic        w_accept;
  logic        w_abort_take;
  logic        w_byte_end;

  hdlc_bit_stuffer u_stuffer (
    .clk         (clk),
    .reset       (reset),
    .payload_en  (w_payload_en),
    .payload_bit (shift_q[0]),
    .stuff_req   (w_stuff_req)
  );

`ifdef HDLC_TX_ABORT_EN
  assign w_abort_take = abort && ((state_q == ST_DATA) || (state_q == ST_STUFF));
`else
  logic w_unused_abort;
  assign w_unused_abort = abort;
  assign w_abort_take   = 1'b0;
`endif

  // Upstream handshake: open on the last bit launched before a byte is needed
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE:  in_ready = (flag_idx_q == C_LAST_BIT);
      ST_DATA:  in_ready = (bit_idx_q == C_LAST_BIT) && !w_stuff_req && !last_q;
      ST_STUFF: in_ready = tail_q && !last_q;
      ST_DRAIN: in_ready = 1'b1;
      default:  in_ready = 1'b0;
    endcase
    if (reset) begin
      in_ready = 1'b0;
    end
  end

  assign w_accept = in_valid && in_ready;

  // A byte finishes when bit7 (or the stuff bit after it) launches this edge
  assign w_byte_end = !w_abort_take &&
                      (((state_q == ST_DATA) && (bit_idx_q == C_LAST_BIT) && !w_stuff_req) ||
                       ((state_q == ST_STUFF) && tail_q));

  // Next-state and next-bit selection
  always_comb begin
    state_d      = state_q;
    flag_idx_d   = flag_idx_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    last_d       = last_q;
    tail_d       = tail_q;
    drain_d      = drain_q;
    abort_cnt_d  = abort_cnt_q;
    dout_d       = 1'b1;
    underrun_d   = 1'b0;
    w_payload_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        dout_d     = flag_bit(flag_idx_q);
        flag_idx_d = flag_idx_q + 3'd1;
        if (w_accept) begin
          state_d   = ST_DATA;
          shift_d   = in_data;
          last_d    = in_last;
          bit_idx_d = 3'd0;
        end
      end
      ST_DATA: begin
        dout_d       = shift_q[0];
        w_payload_en = 1'b1;
        shift_d      = {1'b0, shift_q[7:1]};
        bit_idx_d    = bit_idx_q + 3'd1;
        if (w_stuff_req) begin
          state_d = ST_STUFF;
          tail_d  = (bit_idx_q == C_LAST_BIT);
        end
      end
      ST_STUFF: begin
        dout_d = 1'b0;
        if (!tail_q) begin
          state_d = ST_DATA;
        end
      end
      ST_ABORT7: begin
        dout_d      = 1'b1;
        abort_cnt_d = abort_cnt_q + 3'd1;
        if (abort_cnt_q == C_ABORT_LAST) begin
          flag_idx_d = 3'd0;
          state_d    = drain_q ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        dout_d     = flag_bit(flag_idx_q);
        flag_idx_d = flag_idx_q + 3'd1;
        if (w_accept && in_last) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        flag_idx_d = 3'd0;
      end
    endcase

    if (w_byte_end) begin
      tail_d = 1'b0;
      if (last_q) begin
        state_d    = ST_IDLE;
        flag_idx_d = 3'd0;
      end else if (in_valid) begin
        state_d   = ST_DATA;
        shift_d   = in_data;
        last_d    = in_last;
        bit_idx_d = 3'd0;
      end else begin
        underrun_d = 1'b1;
`ifdef HDLC_TX_ABORT_EN
        state_d     = ST_ABORT7;
        abort_cnt_d = 3'd0;
        drain_d     = 1'b0;
`else
        state_d    = ST_IDLE;
        flag_idx_d = 3'd0;
`endif
      end
    end

    // Abort replaces whatever would have launched, including a last-byte accept
    if (w_abort_take) begin
      dout_d       = 1'b1;
      w_payload_en = 1'b0;
      tail_d       = 1'b0;
      state_d      = ST_ABORT7;
      abort_cnt_d  = 3'd1;
      drain_d      = !(last_q || (w_accept && in_last));
    end

    busy_d = (state_d != ST_IDLE);
  end

  // FSM, datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      flag_idx_q  <= 3'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      last_q      <= 1'b0;
      tail_q      <= 1'b0;
      drain_q     <= 1'b0;
      abort_cnt_q <= 3'd0;
      dout_q      <= 1'b1;
      underrun_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flag_idx_q  <= flag_idx_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      last_q      <= last_d;
      tail_q      <= tail_d;
      drain_q     <= drain_d;
      abort_cnt_q <= abort_cnt_d;
      dout_q      <= dout_d;
      underrun_q  <= underrun_d;
      busy_q      <= busy_d;
    end
  end

  assign dout     = dout_q;
  assign underrun = underrun_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_hdlc_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdlc_tx_framer
// Description : Directed self-checking bench for hdlc_tx_framer. Expected
//               serial streams are written out by hand as '0'/'1' strings in
//               launch order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdlc_tx_framer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       abort = 1'b0;
  logic       in_ready;
  logic       dout;
  logic       underrun;
  logic       busy;

  int errors = 0;
  int checks = 0;

  hdlc_tx_framer dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .abort    (abort),
    .dout     (dout),
    .underrun (underrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: the bit launched on this edge must equal exp
  task automatic tick(input string tag, input logic exp);
    @(posedge clk);
    #1;
    chk(tag, dout, exp);
  endtask

  // Sequence of launched bits written in launch order
  task automatic seq(input string tag, input string bits);
    for (int i = 0; i < bits.len(); i++) begin
      tick(tag, bits[i] == "1");
    end
  endtask

  // Seven flag bits from flag position 0, then offer a byte that is taken
  // on the edge launching the closing zero of that flag
  task automatic open_frame(input string tag, input logic [7:0] data, input logic last);
    seq({tag, "_flag"}, "0111111");
    chk({tag, "_rdy_idle"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    tick({tag, "_sof"}, 1'b0);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", dout, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    #1;
    chk("rst_ready_valid", in_ready, 1'b0);
    in_valid = 1'b0;
    reset = 1'b0;

    // Idle: two back-to-back flags, ready only on the last flag bit
    for (int i = 0; i < 16; i++) begin
      tick("idle_flag", (i % 8 != 0) && (i % 8 != 7));
      chk("idle_busy", busy, 1'b0);
      chk("idle_rdy", in_ready, (i % 8) == 6);
    end

    // 0xFF last: stuff after five ones
    open_frame("ff", 8'hFF, 1'b1);
    seq("ff_a", "11111");
    chk("ff_busy", busy, 1'b1);
    tick("ff_stuff", 1'b0);
    chk("ff_busy_stuff", busy, 1'b1);
    seq("ff_b", "11");
    chk("ff_rdy_last", in_ready, 1'b0);
    tick("ff_b7", 1'b1);
    chk("ff_busy_end", busy, 1'b0);

    // 0x7E last: stuffed zero keeps the payload from looking like a flag
`ifndef HDLC_TX_ABORT_EN
    abort = 1'b1;
`endif
    open_frame("7e", 8'h7E, 1'b1);
    seq("7e_bits", "011111010");
    abort = 1'b0;
    chk("7e_busy_end", busy, 1'b0);

    // 0xF8 then 0x01: stuff after bit7 of a non-final byte, then chaining
    open_frame("f8", 8'hF8, 1'b0);
    seq("f8_bits", "0001111");
    chk("f8_rdy_b6", in_ready, 1'b0);
    tick("f8_b7", 1'b1);
    chk("f8_rdy_stuff", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h01;
    in_last  = 1'b1;
    tick("f8_stuff", 1'b0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    seq("01_bits", "1000000");
    chk("01_rdy_last", in_ready, 1'b0);
    tick("01_b7", 1'b0);
    chk("01_busy_end", busy, 1'b0);

    // 0x0F, 0xF0 last back-to-back: ready once per byte, no gap
    open_frame("0f", 8'h0F, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hF0;
    in_last  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick("0f_bits", i < 4);
      chk("0f_rdy", in_ready, i == 6);
    end
    tick("0f_b7", 1'b0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick("f0_bits", i >= 4);
      chk("f0_rdy", in_ready, 1'b0);
    end
    tick("f0_b7", 1'b1);
    chk("f0_busy_end", busy, 1'b0);

    // Underrun: second byte missing
    open_frame("ur", 8'h00, 1'b0);
    seq("ur_bits", "0000000");
    chk("ur_rdy", in_ready, 1'b1);
    chk("ur_pulse_pre", underrun, 1'b0);
    tick("ur_b7", 1'b0);
    chk("ur_pulse", underrun, 1'b1);
`ifdef HDLC_TX_ABORT_EN
    tick("ur_abort", 1'b1);
    chk("ur_pulse_end", underrun, 1'b0);
    chk("ur_busy_abort", busy, 1'b1);
    seq("ur_abort", "111111");
    chk("ur_busy_end", busy, 1'b0);
`else
    tick("ur_close", 1'b0);
    chk("ur_pulse_end", underrun, 1'b0);
    chk("ur_busy_end", busy, 1'b0);
    seq("ur_close", "1111110");
`endif

`ifdef HDLC_TX_ABORT_EN
    // Abort during byte 1 of 3: seven ones, then drain bytes 2 and 3
    open_frame("ab", 8'h00, 1'b0);
    seq("ab_bits", "00");
    abort = 1'b1;
    tick("ab_first", 1'b1);
    abort = 1'b0;
    seq("ab_ones", "111111");
    chk("ab_busy_drain", busy, 1'b1);
    chk("ab_rdy_drain", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b0;
    tick("ab_drain0", 1'b0);
    chk("ab_busy_b2", busy, 1'b1);
    in_data  = 8'hAA;
    in_last  = 1'b1;
    tick("ab_drain1", 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("ab_busy_end", busy, 1'b0);
    seq("ab_flag", "111110");
`endif

    // Reset in the middle of a frame
    open_frame("mr", 8'hFF, 1'b1);
    seq("mr_bits", "111");
    reset = 1'b1;
    #1;
    chk("mr_dout", dout, 1'b1);
    chk("mr_busy", busy, 1'b0);
    chk("mr_rdy", in_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick("mr_flag0", 1'b0);
    chk("mr_busy_after", busy, 1'b0);
    seq("mr_flag", "1111110");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
